// File: rtl/viterbi_param_dec.sv
// Hard-decision Viterbi decoder, constraint length K, rate 1/N.
// Register-exchange survivors, metric normalisation, re-encode BER.
module viterbi_param_dec #(
    parameter int K = 3,
    parameter int N = 2,
    parameter logic [N*K-1:0] POLYS = {3'b101, 3'b111},
    parameter int TB_DEPTH = 15,
    parameter int PM_W = 8,
    parameter int ERR_W = 8,
    parameter int NORM_W = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              sink_val,
    output logic              sink_rdy,
    input  logic              sink_sop,
    input  logic [N-1:0]      rr,
    input  logic [N-1:0]      eras_sym,
    input  logic              ber_clear,
    output logic              source_val,
    input  logic              source_rdy,
    output logic              decbit,
    output logic [ERR_W-1:0]  numerr,
    output logic [NORM_W-1:0] normalizations
);

    localparam int S = 1 << (K - 1);
    localparam int SW = K - 1;
    localparam int FW = $clog2(TB_DEPTH + 1);
    localparam int BMW = $clog2(N + 1);
    localparam logic [PM_W-1:0] HALF = {1'b1, {(PM_W-1){1'b0}}};

    logic [PM_W-1:0]     pm       [S];
    logic [TB_DEPTH-1:0] surv     [S];
    logic [PM_W-1:0]     pm_base  [S];
    logic [PM_W-1:0]     acs_pm   [S];
    logic [TB_DEPTH:0]   acs_ext  [S];
    logic [PM_W-1:0]     new_pm   [S];
    logic [N-1:0]        dly_rr   [TB_DEPTH];
    logic [N-1:0]        dly_er   [TB_DEPTH];

    logic            up;
    logic [FW-1:0]   fill;
    logic [FW-1:0]   fill_base;
    logic [K-2:0]    enc;
    logic            acc;
    logic            emit;
    logic            norm;
    logic            dec;
    logic [SW-1:0]   best;
    logic [PM_W-1:0] mn;
    logic [BMW-1:0]  errs;
    logic [ERR_W:0]  esum;

    // Hamming distance of a branch label against a symbol, erasures skipped.
    function automatic logic [BMW-1:0] branch(
        input logic [K-1:0] v,
        input logic [N-1:0] r,
        input logic [N-1:0] e
    );
        logic [BMW-1:0] c;
        c = '0;
        for (int j = 0; j < N; j++)
            if (!e[j] && (r[j] != ^(POLYS[j*K +: K] & v)))
                c = c + BMW'(1);
        return c;
    endfunction

    function automatic logic [PM_W-1:0] sat_add(
        input logic [PM_W-1:0] a,
        input logic [BMW-1:0]  b
    );
        logic [PM_W:0] t;
        t = {1'b0, a} + (PM_W+1)'(b);
        return t[PM_W] ? '1 : t[PM_W-1:0];
    endfunction

    assign sink_rdy = up && (!source_val || source_rdy);
    assign acc = sink_val && sink_rdy;
    assign fill_base = sink_sop ? '0 : fill;
    assign emit = !sink_sop && (fill_base >= FW'(TB_DEPTH));

    // Add-compare-select over all states, then pick the best and normalise.
    always_comb begin
        logic [SW-1:0]   qv;
        logic [SW-1:0]   p0;
        logic [SW-1:0]   p1;
        logic [PM_W-1:0] c0;
        logic [PM_W-1:0] c1;
        logic            bq;
        for (int s = 0; s < S; s++)
            pm_base[s] = sink_sop ? ((s == 0) ? '0 : HALF) : pm[s];
        for (int q = 0; q < S; q++) begin
            qv = SW'(q);
            bq = qv[SW-1];
            p0 = {qv[SW-2:0], 1'b0};
            p1 = {qv[SW-2:0], 1'b1};
            c0 = sat_add(pm_base[p0], branch({bq, p0}, rr, eras_sym));
            c1 = sat_add(pm_base[p1], branch({bq, p1}, rr, eras_sym));
            // The extra LSB is the bit leaving the survivor window.
            if (c1 < c0) begin
                acs_pm[q]  = c1;
                acs_ext[q] = {bq, surv[p1]};
            end else begin
                acs_pm[q]  = c0;
                acs_ext[q] = {bq, surv[p0]};
            end
        end
        mn = acs_pm[0];
        best = '0;
        for (int s = 1; s < S; s++)
            if (acs_pm[s] < mn) begin
                mn = acs_pm[s];
                best = SW'(s);
            end
        norm = (mn >= HALF);
        for (int s = 0; s < S; s++)
            new_pm[s] = norm ? acs_pm[s] - HALF : acs_pm[s];
        dec = acs_ext[best][0];
        errs = branch({dec, enc}, dly_rr[TB_DEPTH-1], dly_er[TB_DEPTH-1]);
        esum = {1'b0, numerr} + (ERR_W+1)'(errs);
    end

    // Trellis state, output register, BER and normalisation counters.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            up <= 1'b0;
            source_val <= 1'b0;
            decbit <= 1'b0;
            numerr <= '0;
            normalizations <= '0;
            fill <= '0;
            enc <= '0;
            for (int s = 0; s < S; s++) begin
                pm[s] <= '0;
                surv[s] <= '0;
            end
            for (int i = 0; i < TB_DEPTH; i++) begin
                dly_rr[i] <= '0;
                dly_er[i] <= '0;
            end
        end else begin
            up <= 1'b1;
            if (acc) begin
                for (int s = 0; s < S; s++) begin
                    pm[s] <= new_pm[s];
                    surv[s] <= acs_ext[s][TB_DEPTH:1];
                end
                dly_rr[0] <= rr;
                dly_er[0] <= eras_sym;
                for (int i = TB_DEPTH - 1; i > 0; i--) begin
                    dly_rr[i] <= dly_rr[i-1];
                    dly_er[i] <= dly_er[i-1];
                end
                if (fill_base < FW'(TB_DEPTH))
                    fill <= fill_base + FW'(1);
                else
                    fill <= fill_base;
                if (norm)
                    normalizations <= normalizations + NORM_W'(1);
                source_val <= emit;
                if (sink_sop)
                    enc <= '0;
                else if (emit) begin
                    decbit <= dec;
                    enc <= {dec, enc[K-2:1]};
                end
            end else if (source_rdy) begin
                source_val <= 1'b0;
            end
            if (ber_clear)
                numerr <= '0;
            else if (acc && emit)
                numerr <= esum[ERR_W] ? '1 : esum[ERR_W-1:0];
        end
    end

endmodule

// File: tb/tb_viterbi_param_dec.sv
// Bench for viterbi_param_dec: default instance plus a PM_W=4 instance,
// both checked every cycle against a path-list Viterbi model.
module tb_viterbi_param_dec;

    localparam int TD = 15;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic sink_val = 1'b0;
    logic sink_sop = 1'b0;
    logic ber_clear = 1'b0;
    logic source_rdy = 1'b1;
    logic [1:0] rr = '0;
    logic [1:0] eras_sym = '0;
    logic sink_rdy, source_val, decbit;
    logic [7:0] numerr, normalizations;
    logic sink_rdy4, source_val4, decbit4;
    logic [7:0] numerr4, normalizations4;

    int checks = 0;
    int errors = 0;
    int got[$];

    int     m_pm   [2][4];
    longint m_path [2][4];
    int     m_hist [2][16];
    int     m_fill [2];
    int     m_enc  [2];
    int     m_val  [2];
    int     m_dec  [2];
    int     m_err  [2];
    int     m_norm [2];
    bit     m_up;

    always #5 clk = ~clk;

    viterbi_param_dec dut (
        .clk(clk), .reset_n(reset_n),
        .sink_val(sink_val), .sink_rdy(sink_rdy), .sink_sop(sink_sop),
        .rr(rr), .eras_sym(eras_sym), .ber_clear(ber_clear),
        .source_val(source_val), .source_rdy(source_rdy), .decbit(decbit),
        .numerr(numerr), .normalizations(normalizations)
    );

    viterbi_param_dec #(.PM_W(4)) dut4 (
        .clk(clk), .reset_n(reset_n),
        .sink_val(sink_val), .sink_rdy(sink_rdy4), .sink_sop(sink_sop),
        .rr(rr), .eras_sym(eras_sym), .ber_clear(ber_clear),
        .source_val(source_val4), .source_rdy(source_rdy), .decbit(decbit4),
        .numerr(numerr4), .normalizations(normalizations4)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic int par(input int x);
        return (x ^ (x >> 1) ^ (x >> 2)) & 1;
    endfunction

    // Code symbol {e1,e0} leaving state st on input b; generators 111 and 101.
    function automatic int enc_sym(input int st, input int b);
        int x;
        x = b * 4 + st;
        return par(x & 5) * 2 + par(x & 7);
    endfunction

    task automatic mreset();
        m_up = 0;
        for (int i = 0; i < 2; i++) begin
            for (int s = 0; s < 4; s++) begin
                m_pm[i][s] = 0;
                m_path[i][s] = 0;
            end
            for (int k = 0; k < 16; k++) m_hist[i][k] = 0;
            m_fill[i] = 0; m_enc[i] = 0; m_val[i] = 0;
            m_dec[i] = 0; m_err[i] = 0; m_norm[i] = 0;
        end
    endtask

    task automatic mstep(input int i, input bit acc, input int pmw);
        int half, maxv, q, bm, cand, mn, best, e, errs, dec, cur;
        int npm[4];
        longint npath[4];
        half = 1 << (pmw - 1);
        maxv = (1 << pmw) - 1;
        if (acc) begin
            if (sink_sop) begin
                m_pm[i][0] = 0;
                for (int s = 1; s < 4; s++) m_pm[i][s] = half;
                m_fill[i] = 0;
                m_enc[i] = 0;
            end
            for (int s = 0; s < 4; s++) begin
                npm[s] = 1 << 30;
                npath[s] = 0;
            end
            for (int p = 0; p < 4; p++)
                for (int b = 0; b < 2; b++) begin
                    e = enc_sym(p, b);
                    bm = 0;
                    for (int j = 0; j < 2; j++)
                        if (!eras_sym[j] && (int'(rr[j]) != ((e >> j) & 1))) bm++;
                    cand = m_pm[i][p] + bm;
                    if (cand > maxv) cand = maxv;
                    q = b * 2 + p / 2;
                    if (cand < npm[q]) begin
                        npm[q] = cand;
                        npath[q] = ((m_path[i][p] << 1) | longint'(b)) & 64'hFFFF;
                    end
                end
            mn = npm[0];
            best = 0;
            for (int s = 1; s < 4; s++)
                if (npm[s] < mn) begin
                    mn = npm[s];
                    best = s;
                end
            if (mn >= half) begin
                for (int s = 0; s < 4; s++) npm[s] -= half;
                m_norm[i] = (m_norm[i] + 1) & 255;
            end
            cur = int'(eras_sym) * 4 + int'(rr);
            for (int k = 15; k > 0; k--) m_hist[i][k] = m_hist[i][k-1];
            m_hist[i][0] = cur;
            if (m_fill[i] >= TD) begin
                dec = int'((npath[best] >> TD) & 1);
                m_val[i] = 1;
                m_dec[i] = dec;
                e = enc_sym(m_enc[i], dec);
                errs = 0;
                for (int j = 0; j < 2; j++)
                    if (((m_hist[i][15] >> (2 + j)) & 1) == 0 &&
                        ((m_hist[i][15] >> j) & 1) != ((e >> j) & 1)) errs++;
                m_enc[i] = dec * 2 + m_enc[i] / 2;
                m_err[i] = m_err[i] + errs;
                if (m_err[i] > 255) m_err[i] = 255;
            end else begin
                m_val[i] = 0;
            end
            if (m_fill[i] < TD) m_fill[i]++;
            for (int s = 0; s < 4; s++) begin
                m_pm[i][s] = npm[s];
                m_path[i][s] = npath[s];
            end
        end else if (source_rdy) begin
            m_val[i] = 0;
        end
        if (ber_clear) m_err[i] = 0;
    endtask

    initial begin
        bit acc;
        mreset();
        forever begin
            @(posedge clk or negedge reset_n);
            if (!reset_n) begin
                mreset();
            end else begin
                acc = sink_val && m_up && (m_val[0] == 0 || source_rdy);
                mstep(0, acc, 8);
                mstep(1, acc, 4);
                m_up = 1;
            end
        end
    end

    task automatic cmp(input int i, input logic v, input logic r, input logic d,
                       input logic [7:0] ne, input logic [7:0] nn);
        chk($sformatf("source_val%0d", i), 32'(v), m_val[i]);
        chk($sformatf("sink_rdy%0d", i), 32'(r),
            32'(m_up && (m_val[i] == 0 || source_rdy)));
        chk($sformatf("numerr%0d", i), 32'(ne), m_err[i]);
        chk($sformatf("normalizations%0d", i), 32'(nn), m_norm[i]);
        if (m_val[i] != 0) chk($sformatf("decbit%0d", i), 32'(d), m_dec[i]);
    endtask

    initial begin
        @(posedge clk);
        forever begin
            @(negedge clk);
            cmp(0, source_val, sink_rdy, decbit, numerr, normalizations);
            cmp(1, source_val4, sink_rdy4, decbit4, numerr4, normalizations4);
            if (source_val && source_rdy) got.push_back(int'(decbit));
        end
    end

    task automatic send(input logic [1:0] r, input logic [1:0] e, input logic sop);
        bit done;
        done = 0;
        sink_val = 1'b1;
        rr = r;
        eras_sym = e;
        sink_sop = sop;
        for (int t = 0; t < 50 && !done; t++) begin
            @(negedge clk);
            if (sink_rdy) done = 1;
            @(posedge clk);
            #1;
        end
        sink_sop = 1'b0;
        if (!done) chk("accept_timeout", 0, 1);
    endtask

    task automatic frame(input int bits[$], input int flip, input int erase);
        int st, s;
        logic [1:0] r, e;
        st = 0;
        got.delete();
        for (int k = 0; k < bits.size(); k++) begin
            s = enc_sym(st, bits[k]);
            st = bits[k] * 2 + st / 2;
            r = 2'(s);
            e = 2'b00;
            if (k == flip) r[0] = ~r[0];
            if (k == erase) begin
                r = 2'b00;
                e = 2'b11;
            end
            send(r, e, k == 0);
        end
        sink_val = 1'b0;
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic check_got(input string nm, input int bits[$]);
        chk({nm, "_count"}, got.size(), bits.size() - TD);
        for (int k = 0; k < got.size() && k < bits.size(); k++)
            chk($sformatf("%s_bit%0d", nm, k), got[k], bits[k]);
    endtask

    task automatic clear_ber();
        ber_clear = 1'b1;
        @(posedge clk);
        #1;
        ber_clear = 1'b0;
    endtask

    task automatic stall();
        logic held;
        repeat (25) @(posedge clk);
        #2;
        source_rdy = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (c == 0) held = decbit;
            chk("t5_val_held", 32'(source_val), 1);
            chk("t5_sink_rdy", 32'(sink_rdy), 0);
            chk("t5_decbit_stable", 32'(decbit), 32'(held));
        end
        @(posedge clk);
        #2;
        source_rdy = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int b2[$];
        int b5[$];
        int n0, st;

        // T1: reset state, sink_rdy timing after release
        @(posedge clk);
        @(negedge clk);
        chk("rst_source_val", 32'(source_val), 0);
        chk("rst_sink_rdy", 32'(sink_rdy), 0);
        chk("rst_numerr", 32'(numerr), 0);
        chk("rst_norm", 32'(normalizations), 0);
        chk("rst_decbit", 32'(decbit), 0);
        @(posedge clk);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        @(negedge clk);
        chk("rdy_before_edge", 32'(sink_rdy), 0);
        @(negedge clk);
        chk("rdy_after_edge", 32'(sink_rdy), 1);
        @(posedge clk);
        #1;

        // Pin the bench encoder to the hand-derived symbols 11,01,00,10
        st = 0;
        chk("enc_s0", enc_sym(st, 1), 3); st = 2;
        chk("enc_s1", enc_sym(st, 0), 1); st = 1;
        chk("enc_s2", enc_sym(st, 1), 0); st = 2;
        chk("enc_s3", enc_sym(st, 1), 2);

        // T2: clean frame
        b2 = '{1, 0, 1, 1};
        for (int k = 0; k < 28; k++) b2.push_back(0);
        frame(b2, -1, -1);
        check_got("t2", b2);
        chk("t2_lit0", got[0], 1);
        chk("t2_lit1", got[1], 0);
        chk("t2_lit2", got[2], 1);
        chk("t2_lit3", got[3], 1);
        chk("t2_lit4", got[4], 0);
        chk("t2_numerr", 32'(numerr), 0);

        // T3: single channel error
        clear_ber();
        frame(b2, 5, -1);
        check_got("t3", b2);
        chk("t3_numerr", 32'(numerr), 1);
        chk("t3_numerr4", 32'(numerr4), 1);

        // T4: erased symbol
        clear_ber();
        frame(b2, -1, 3);
        check_got("t4", b2);
        chk("t4_numerr", 32'(numerr), 0);

        // T5: backpressure mid-frame
        for (int k = 0; k < 40; k++) b5.push_back(((k * 7 + 3) % 5) < 2 ? 1 : 0);
        fork
            frame(b5, -1, -1);
            stall();
        join
        check_got("t5", b5);

        // T1: reset asserted mid-stream
        send(2'b00, 2'b00, 1'b1);
        for (int k = 0; k < 19; k++) send(2'b00, 2'b00, 1'b0);
        reset_n = 1'b0;
        @(negedge clk);
        chk("mid_source_val", 32'(source_val), 0);
        chk("mid_sink_rdy", 32'(sink_rdy), 0);
        chk("mid_numerr", 32'(numerr), 0);
        chk("mid_norm", 32'(normalizations), 0);
        repeat (3) @(posedge clk);
        #1;
        reset_n = 1'b1;
        @(negedge clk);
        chk("mid_rdy_before_edge", 32'(sink_rdy), 0);
        @(negedge clk);
        chk("mid_rdy_after_edge", 32'(sink_rdy), 1);
        sink_val = 1'b0;
        @(posedge clk);
        #1;

        // T6: all-erroneous symbols, normalisation and saturation
        n0 = int'(normalizations4);
        for (int k = 0; k < 64; k++) send(2'b11, 2'b00, k == 0);
        sink_val = 1'b0;
        @(negedge clk);
        chk("t6_norm4_grew", 32'(int'(normalizations4) > n0), 1);
        @(posedge clk);
        #1;
        clear_ber();
        @(negedge clk);
        chk("t6_clear", 32'(numerr), 0);
        chk("t6_clear4", 32'(numerr4), 0);
        @(posedge clk);
        #1;
        for (int k = 0; k < 1200; k++) send(2'b11, 2'b00, 1'b0);
        sink_val = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("t6_sat", 32'(numerr), 255);
        chk("t6_sat4", 32'(numerr4), 255);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
